// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Fetch-request bundle between the PC sequencer (master) and the
//   instruction memory (slave).
//
//   Handshake: a request is offered while fetch_valid=1 and is accepted
//   ("fires") on a rising edge where fetch_valid=1 and fetch_ready=1.
//   While a request is pending, pc stays stable unless a jump, branch or
//   return redirect is applied. A redirect abandons the pending request
//   and offers the new pc instead.
//
//   Signals:
//     pc          16  fetch address (master -> slave)
//     fetch_valid  1  pc is a valid request (master -> slave)
//     fetch_ready  1  request accepted this cycle (slave -> master)
interface pc_sequencer_if;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        fetch_ready;

  modport master (output pc, output fetch_valid, input fetch_ready);
  modport slave  (input pc, input fetch_valid, output fetch_ready);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter register and next-PC selection. Offers pc as a fetch
//   request, advances to pc_plus_one when the request is accepted, and
//   applies jump / branch / return redirects, stalls and halt. Counts
//   applied redirects in a saturating 8-bit counter.
//
//   Optional feature: define PC_SEQUENCER_RAS_EN to build a RAS_DEPTH-entry
//   circular return-address stack (push on jump+call, pop on lone ret).
//
//   Ports:
//     clk, reset       clock, synchronous active-high reset
//     fif (master)     pc / fetch_valid / fetch_ready handshake
//     pc_plus_one      incrementer result (pc+1)
//     stall            hold pc
//     jump/jump_target, branch_taken/branch_target   redirects
//     call, ret        RAS push (with jump) / pop
//     halt / halted    enter and report the terminal HALTED state
//     redirect_count   saturating count of applied redirects
//     ras_underflow    one-cycle pulse on ret with an empty stack
//     dbg_state        current FSM state (BOOT=0, RUN=1, HALTED=2)
module pc_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_sequencer_if.master        fif,
  input  logic [15:0]           pc_plus_one,
  input  logic                  stall,
  input  logic                  jump,
  input  logic [15:0]           jump_target,
  input  logic                  branch_taken,
  input  logic [15:0]           branch_target,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  halt,
  output logic                  halted,
  output logic [7:0]            redirect_count,
  output logic                  ras_underflow,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        fv_q;
  logic        halted_q;
  logic [7:0]  cnt_q;
  logic        uf_q, underflow_d;
  logic        redirect, ras_push, ras_pop;

  logic        call_en, ret_en, ras_empty;
  logic [15:0] ras_top;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [15:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] sp_q;        // slot the next push writes
  logic [CW-1:0] cnt_ras_q;   // valid entries, capped at RAS_DEPTH
  logic [PW-1:0] sp_inc, sp_dec;

  assign sp_inc    = (sp_q == PW'(RAS_DEPTH - 1)) ? '0 : sp_q + 1'b1;
  assign sp_dec    = (sp_q == '0) ? PW'(RAS_DEPTH - 1) : sp_q - 1'b1;
  assign call_en   = call;
  assign ret_en    = ret;
  assign ras_empty = (cnt_ras_q == '0);
  assign ras_top   = ras_mem[sp_dec];

  // A full push overwrites the oldest slot because the write pointer
  // simply wraps onto it; occupancy saturates at RAS_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q      <= '0;
      cnt_ras_q <= '0;
    end else if (ras_push) begin
      ras_mem[sp_q] <= pc_plus_one;
      sp_q          <= sp_inc;
      if (cnt_ras_q != CW'(RAS_DEPTH)) cnt_ras_q <= cnt_ras_q + 1'b1;
    end else if (ras_pop) begin
      sp_q      <= sp_dec;
      cnt_ras_q <= cnt_ras_q - 1'b1;
    end
  end
`else
  assign call_en   = 1'b0;
  assign ret_en    = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_top   = '0;
  wire unused_ok = &{1'b0, call, ret, ras_push, ras_pop, RAS_DEPTH[4:0]};
`endif

  // Next-state / next-pc selection. In RUN, fetch_valid is 1, so a fire
  // reduces to fetch_ready.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redirect    = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    underflow_d = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (jump) begin
          pc_d     = jump_target;
          redirect = 1'b1;
          ras_push = call_en;
        end else if (branch_taken) begin
          pc_d     = branch_target;
          redirect = 1'b1;
        end else if (ret_en && !ras_empty) begin
          pc_d     = ras_top;
          redirect = 1'b1;
          ras_pop  = 1'b1;
        end else begin
          // Reaching here with ret set means the stack was empty.
          underflow_d = ret_en;
          if (halt)                 state_d = HALTED;
          else if (stall)           pc_d    = pc_q;
          else if (fif.fetch_ready) pc_d    = pc_plus_one;
        end
      end
      default: ;  // HALTED: frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= 8'h00;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      fv_q     <= (state_d == RUN);
      halted_q <= (state_d == HALTED);
      if (redirect && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'h01;
      uf_q     <= underflow_d;
    end
  end

  assign fif.pc          = pc_q;
  assign fif.fetch_valid = fv_q;
  assign halted          = halted_q;
  assign redirect_count  = cnt_q;
  assign ras_underflow   = uf_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] pc_plus_one;
  logic        stall, jump, branch_taken, call, ret, halt;
  logic [15:0] jump_target, branch_target;
  logic        halted, ras_underflow;
  logic [7:0]  redirect_count;
  logic [1:0]  dbg_state;

  pc_sequencer_if fif ();

  // Behavioural incrementer feeding the sequencer.
  assign pc_plus_one = fif.pc + 16'd1;

  pc_sequencer #(.RESET_VECTOR(16'h0000), .RAS_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .fif            (fif),
    .pc_plus_one    (pc_plus_one),
    .stall          (stall),
    .jump           (jump),
    .jump_target    (jump_target),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .call           (call),
    .ret            (ret),
    .halt           (halt),
    .halted         (halted),
    .redirect_count (redirect_count),
    .ras_underflow  (ras_underflow),
    .dbg_state      (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; jump = 0; branch_taken = 0; call = 0; ret = 0; halt = 0;
    jump_target = 16'h0000; branch_target = 16'h0000;
  endtask

  task automatic do_jump(input logic [15:0] t, input logic c);
    idle();
    jump = 1; jump_target = t; call = c;
    tick();
    idle();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    fif.fetch_ready = 0;
    tick(); tick();
    chk("rst_pc", fif.pc, 16'h0000);
    chk("rst_fv", {15'd0, fif.fetch_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_cnt", {8'd0, redirect_count}, 16'd0);
    chk("rst_uf", {15'd0, ras_underflow}, 16'd0);
    chk("rst_state", {14'd0, dbg_state}, 16'd0);

    // boot then sequential fetch
    reset = 0;
    fif.fetch_ready = 1;
    tick();
    chk("boot_pc", fif.pc, 16'h0000);
    chk("run_fv", {15'd0, fif.fetch_valid}, 16'd1);
    tick(); chk("seq1", fif.pc, 16'h0001);
    tick(); chk("seq2", fif.pc, 16'h0002);
    tick(); chk("seq3", fif.pc, 16'h0003);

    // wrap-around
    do_jump(16'hFFFF, 0);
    chk("ld_ffff", fif.pc, 16'hFFFF);
    chk("cnt1", {8'd0, redirect_count}, 16'd1);
    tick();
    chk("wrap_pc", fif.pc, 16'h0000);
    chk("wrap_cnt", {8'd0, redirect_count}, 16'd1);

    // stall and redirect priority
    do_jump(16'h0010, 0);
    stall = 1;
    tick(); chk("stall_hold", fif.pc, 16'h0010);
    jump = 1; jump_target = 16'h0200; branch_taken = 1; branch_target = 16'h0300;
    tick();
    chk("jump_prio", fif.pc, 16'h0200);
    chk("jump_cnt", {8'd0, redirect_count}, 16'd3);
    idle();
    branch_taken = 1; branch_target = 16'h0300;
    tick();
    chk("branch_pc", fif.pc, 16'h0300);
    chk("branch_cnt", {8'd0, redirect_count}, 16'd4);
    idle();

    // back-pressure
    do_jump(16'h0040, 0);
    fif.fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_pc", fif.pc, 16'h0040);
      chk("bp_fv", {15'd0, fif.fetch_valid}, 16'd1);
    end
    fif.fetch_ready = 1;
    tick(); chk("bp_release", fif.pc, 16'h0041);

    // halt with a redirect: redirect wins for that cycle
    halt = 1; jump = 1; jump_target = 16'h0080;
    tick();
    chk("hr_pc", fif.pc, 16'h0080);
    chk("hr_halted", {15'd0, halted}, 16'd0);
    chk("hr_cnt", {8'd0, redirect_count}, 16'd6);
    jump = 0;
    tick();
    chk("halt_halted", {15'd0, halted}, 16'd1);
    chk("halt_fv", {15'd0, fif.fetch_valid}, 16'd0);
    chk("halt_pc", fif.pc, 16'h0080);
    jump = 1; jump_target = 16'h0500; halt = 0;
    tick(); tick();
    chk("frozen_pc", fif.pc, 16'h0080);
    chk("frozen_cnt", {8'd0, redirect_count}, 16'd6);
    chk("frozen_halted", {15'd0, halted}, 16'd1);

    // reset mid-operation
    reset = 1;
    tick();
    chk("rr_pc", fif.pc, 16'h0000);
    chk("rr_halted", {15'd0, halted}, 16'd0);
    chk("rr_fv", {15'd0, fif.fetch_valid}, 16'd0);
    chk("rr_cnt", {8'd0, redirect_count}, 16'd0);
    reset = 0; idle();
    tick();
    chk("rr_boot_pc", fif.pc, 16'h0000);
    chk("rr_run_fv", {15'd0, fif.fetch_valid}, 16'd1);

    // redirect counter saturation
    jump = 1;
    for (int i = 0; i < 254; i++) begin
      jump_target = 16'($urandom_range(0, 16'hFFFF));
      tick();
    end
    chk("cnt_fe", {8'd0, redirect_count}, 16'h00FE);
    for (int i = 0; i < 46; i++) begin
      jump_target = 16'h1234;
      tick();
    end
    chk("cnt_sat", {8'd0, redirect_count}, 16'h00FF);
    idle();

`ifdef PC_SEQUENCER_RAS_EN
    reset = 1; tick(); reset = 0;
    tick();  // BOOT -> RUN at 0000
    for (int i = 0; i < 5; i++) tick();
    chk("ras_pc5", fif.pc, 16'h0005);
    do_jump(16'h0100, 1);
    chk("call_pc", fif.pc, 16'h0100);
    ret = 1;
    tick();
    chk("ret_pc", fif.pc, 16'h0006);
    chk("ret_uf", {15'd0, ras_underflow}, 16'd0);
    tick();
    chk("empty_pc", fif.pc, 16'h0007);
    chk("empty_uf", {15'd0, ras_underflow}, 16'd1);
    ret = 0;
    tick();
    chk("uf_pulse", {15'd0, ras_underflow}, 16'd0);
    chk("uf_pc", fif.pc, 16'h0008);
    do_jump(16'h1000, 1);  // push 0009 (overwritten later)
    do_jump(16'h2000, 1);  // push 1001
    do_jump(16'h3000, 1);  // push 2001
    do_jump(16'h4000, 1);  // push 3001
    do_jump(16'h5000, 1);  // push 4001
    ret = 1;
    tick(); chk("pop1", fif.pc, 16'h4001);
    tick(); chk("pop2", fif.pc, 16'h3001);
    tick(); chk("pop3", fif.pc, 16'h2001);
    tick(); chk("pop4", fif.pc, 16'h1001);
    tick();
    chk("pop5_pc", fif.pc, 16'h1002);
    chk("pop5_uf", {15'd0, ras_underflow}, 16'd1);
    idle();
`else
    // without the stack, call/ret are ignored
    jump = 1; jump_target = 16'h0100; call = 1;
    tick(); idle();
    ret = 1;
    tick();
    chk("noras_pc", fif.pc, 16'h0101);
    chk("noras_uf", {15'd0, ras_underflow}, 16'd0);
    idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
